// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack port between the RV32I memory stage (master) and data memory (slave).
interface mem_access_unit_if;
  logic        DmemReq_o;
  logic        DmemWe_o;
  logic [31:0] DmemAddr_o;
  logic [3:0]  DmemBe_o;
  logic [31:0] DmemWdata_o;
  logic        DmemAck_i;
  logic [31:0] DmemRdata_i;

  modport master (
    output DmemReq_o, DmemWe_o, DmemAddr_o, DmemBe_o, DmemWdata_o,
    input  DmemAck_i, DmemRdata_i
  );

  modport slave (
    input  DmemReq_o, DmemWe_o, DmemAddr_o, DmemBe_o, DmemWdata_o,
    output DmemAck_i, DmemRdata_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I memory stage: one req/ack access per load/store, store lane alignment, load extraction/extension.
// Accept->Done_o is 2 cycles plus memory wait; Stall_o holds the pipeline until the single DONE cycle.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              Valid_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        Funct3_i,
  input  logic [31:0]       Addr_i,
  input  logic [31:0]       StoreData_i,
  output logic              Stall_o,
  output logic              Done_o,
  output logic [31:0]       LoadData_o,
  output logic              BusErr_o,
  output logic              Misaligned_o,
  mem_access_unit_if.master dmem
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic          done_q, done_d;
  logic          buserr_q, buserr_d;
  logic [31:0]   load_q, load_d;

  logic        mem_op;
  logic        misaligned;
  logic        accept;
  logic        ack;
  logic        timeout_hit;
  logic [3:0]  be_req;
  logic [31:0] wdata_req;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  // Funct3[1:0]=11 falls into the word case.
  always_comb begin
    mem_op     = Valid_i & (MemRead_i | MemWrite_i);
    misaligned = 1'b0;
    be_req     = 4'b1111;
    wdata_req  = StoreData_i;
    case (Funct3_i[1:0])
      2'b00: begin
        be_req    = 4'b0001 << Addr_i[1:0];
        wdata_req = {4{StoreData_i[7:0]}};
      end
      2'b01: begin
        be_req     = Addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_req  = {2{StoreData_i[15:0]}};
        misaligned = Addr_i[0];
      end
      default: misaligned = (Addr_i[1:0] != 2'b00);
    endcase
    accept      = (state_q == IDLE) & mem_op & ~misaligned;
    ack         = dmem.DmemAck_i;
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  // Registered offset/funct3 select the lane; aligned halves always sit at shift 0 or 16.
  always_comb begin
    rd_shift = dmem.DmemRdata_i >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{rd_shift[7] & ~f3_q[2]}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{rd_shift[15] & ~f3_q[2]}}, rd_shift[15:0]};
      default: load_ext = dmem.DmemRdata_i;
    endcase
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    off_d        = off_q;
    f3_d         = f3_q;
    done_d       = 1'b0;
    buserr_d     = 1'b0;
    load_d       = load_q;
    Stall_o      = 1'b0;
    Misaligned_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d        = '0;
        load_d       = '0;
        Stall_o      = accept;
        Misaligned_o = mem_op & misaligned;
        if (accept) begin
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = {Addr_i[31:2], 2'b00};
          be_d    = be_req;
          wdata_d = MemWrite_i ? wdata_req : '0;
          off_d   = Addr_i[1:0];
          f3_d    = Funct3_i;
        end
      end
      WAIT: begin
        Stall_o = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (ack || timeout_hit) begin
          req_d    = 1'b0;
          we_d     = 1'b0;
          addr_d   = '0;
          be_d     = '0;
          wdata_d  = '0;
          done_d   = 1'b1;
          buserr_d = ~ack;
          load_d   = (ack && !we_q) ? load_ext : '0;
        end
      end
      DONE: begin
        cnt_d  = '0;
        load_d = '0;
      end
      default: ;
    endcase
    if (Rst_i) begin
      Stall_o      = 1'b0;
      Misaligned_o = 1'b0;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      done_q   <= 1'b0;
      buserr_q <= 1'b0;
      load_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
      done_q   <= done_d;
      buserr_q <= buserr_d;
      load_q   <= load_d;
    end
  end

  assign dmem.DmemReq_o   = req_q;
  assign dmem.DmemWe_o    = we_q;
  assign dmem.DmemAddr_o  = addr_q;
  assign dmem.DmemBe_o    = be_q;
  assign dmem.DmemWdata_o = wdata_q;
  assign Done_o           = done_q;
  assign BusErr_o         = buserr_q;
  assign LoadData_o       = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: scripted loads/stores against a delayed-ack memory, results scored at Done_o.
module tb_mem_access_unit;
  logic        Clk_i = 1'b0;
  logic        Rst_i;
  logic        Valid_i, MemRead_i, MemWrite_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Addr_i, StoreData_i;
  logic        Stall_o, Done_o, BusErr_o, Misaligned_o;
  logic [31:0] LoadData_o;

  always #5 Clk_i = ~Clk_i;

  mem_access_unit_if dmem();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Valid_i(Valid_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .Funct3_i(Funct3_i), .Addr_i(Addr_i),
    .StoreData_i(StoreData_i), .Stall_o(Stall_o), .Done_o(Done_o),
    .LoadData_o(LoadData_o), .BusErr_o(BusErr_o), .Misaligned_o(Misaligned_o),
    .dmem(dmem)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 1;
  int          wait_cnt = 0;
  bit          resp_en = 1'b1;
  logic [31:0] mem_rdata = 32'h0;

  // Memory model: ack on the ack_delay-th cycle that DmemReq_o is seen high (-1 never acks).
  always @(negedge Clk_i) begin
    if (resp_en) begin
      if (dmem.DmemReq_o === 1'b1) wait_cnt++;
      else wait_cnt = 0;
      dmem.DmemAck_i   = (dmem.DmemReq_o === 1'b1) && (wait_cnt == ack_delay);
      dmem.DmemRdata_i = dmem.DmemAck_i ? mem_rdata : 32'h0;
    end
  end

  always @(negedge Clk_i) begin
    if (Done_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: Done_o=1 with no access outstanding");
      end else begin
        mon_e = exp_q.pop_front();
        if (LoadData_o !== mon_e.data || BusErr_o !== mon_e.err) begin
          errors++;
          $display("FAIL result: LoadData_o=%h BusErr_o=%b, required %h/%b",
                   LoadData_o, BusErr_o, mon_e.data, mon_e.err);
        end
      end
    end
  end

  task automatic expect_result(input logic [31:0] data, input logic err);
    exp_t e;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
    Valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr;
    Funct3_i = f3; Addr_i = a; StoreData_i = sd;
  endtask

  task automatic clr_op();
    Valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    Funct3_i = 3'b000; Addr_i = 32'h0; StoreData_i = 32'h0;
  endtask

  // Drives one op from posedge+1 and observes it until Done_o (bounded); returns observations only.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        output int lat, output int stall_cyc, output int req_cyc,
                        output logic [31:0] a_o, output logic [3:0] be_o,
                        output logic [31:0] wd_o, output logic we_o);
    lat = -1; stall_cyc = 0; req_cyc = 0;
    a_o = 32'h0; be_o = 4'h0; wd_o = 32'h0; we_o = 1'b0;
    set_op(rd, wr, f3, a, sd);
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk_i);
      if (Stall_o === 1'b1) stall_cyc++;
      if (dmem.DmemReq_o === 1'b1) begin
        if (req_cyc == 0) begin
          a_o = dmem.DmemAddr_o; be_o = dmem.DmemBe_o;
          wd_o = dmem.DmemWdata_o; we_o = dmem.DmemWe_o;
        end
        req_cyc++;
      end
      if (Done_o === 1'b1 && lat < 0) lat = c;
      @(posedge Clk_i); #1;
      if (lat >= 0) break;
    end
    clr_op();
  endtask

  task automatic test_reset();
    Rst_i = 1'b1;
    dmem.DmemAck_i = 1'b0;
    dmem.DmemRdata_i = 32'h0;
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    repeat (2) @(posedge Clk_i);
    @(negedge Clk_i);
    checks++;
    if (Stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall: Stall_o=%b required 0", Stall_o);
    end
    checks++;
    if ({dmem.DmemReq_o, dmem.DmemWe_o, dmem.DmemBe_o, Done_o, BusErr_o} !== 8'h0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b we=%b be=%b done=%b buserr=%b required all 0",
               dmem.DmemReq_o, dmem.DmemWe_o, dmem.DmemBe_o, Done_o, BusErr_o);
    end
    checks++;
    if ({dmem.DmemAddr_o, dmem.DmemWdata_o, LoadData_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h load=%h required 0",
               dmem.DmemAddr_o, dmem.DmemWdata_o, LoadData_o);
    end
    set_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    @(negedge Clk_i);
    checks++;
    if (Misaligned_o !== 1'b0) begin
      errors++; $display("FAIL reset_misaligned: Misaligned_o=%b required 0", Misaligned_o);
    end
    @(posedge Clk_i); #1;
    clr_op();
    Rst_i = 1'b0;
  endtask

  task automatic test_lw();
    int lat, st, rq;
    logic [31:0] a, wd;
    logic [3:0] be;
    logic we;
    ack_delay = 1;
    mem_rdata = 32'hDEADBEEF;
    expect_result(32'hDEADBEEF, 1'b0);
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, lat, st, rq, a, be, wd, we);
    checks++;
    if (lat != 2 || st != 2 || rq != 1) begin
      errors++; $display("FAIL lw_timing: lat=%0d stall=%0d req=%0d required 2/2/1", lat, st, rq);
    end
    checks++;
    if (a !== 32'h100 || be !== 4'b1111 || we !== 1'b0 || wd !== 32'h0) begin
      errors++; $display("FAIL lw_bus: addr=%h be=%b we=%b wdata=%h required 00000100/1111/0/0", a, be, we, wd);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [6];
    logic [31:0] adrs [6];
    logic [31:0] exps [6];
    logic [3:0]  bes  [6];
    int lat, st, rq;
    logic [31:0] a, wd;
    logic [3:0] be;
    logic we;
    f3s  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001};
    adrs = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
    exps = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'h00000034, 32'h00001234};
    bes  = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0001, 4'b0011};
    ack_delay = 1;
    mem_rdata = 32'h80FF1234;
    for (int i = 0; i < 6; i++) begin
      expect_result(exps[i], 1'b0);
      run_op(1'b1, 1'b0, f3s[i], adrs[i], 32'hFFFFFFFF, lat, st, rq, a, be, wd, we);
      checks++;
      if (lat != 2 || be !== bes[i] || a !== {adrs[i][31:2], 2'b00} || wd !== 32'h0) begin
        errors++;
        $display("FAIL load_ext[%0d]: lat=%0d be=%b addr=%h wdata=%h required 2/%b/%h/0",
                 i, lat, be, a, wd, bes[i], {adrs[i][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_store();
    logic        rds  [5];
    logic [2:0]  f3s  [5];
    logic [31:0] adrs [5];
    logic [31:0] sds  [5];
    logic [3:0]  bes  [5];
    logic [31:0] wds  [5];
    int lat, st, rq;
    logic [31:0] a, wd;
    logic [3:0] be;
    logic we;
    rds  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    f3s  = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b000};
    adrs = '{32'h201, 32'h202, 32'h300, 32'h204, 32'h203};
    sds  = '{32'h123456AB, 32'hFFFF1234, 32'hCAFEF00D, 32'h00005678, 32'h0000005A};
    bes  = '{4'b0010, 4'b1100, 4'b1111, 4'b0011, 4'b1000};
    wds  = '{32'hABABABAB, 32'h12341234, 32'hCAFEF00D, 32'h56785678, 32'h5A5A5A5A};
    ack_delay = 1;
    mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      expect_result(32'h0, 1'b0);
      run_op(rds[i], 1'b1, f3s[i], adrs[i], sds[i], lat, st, rq, a, be, wd, we);
      checks++;
      if (lat != 2 || we !== 1'b1 || be !== bes[i] || wd !== wds[i] || a !== {adrs[i][31:2], 2'b00}) begin
        errors++;
        $display("FAIL store[%0d]: lat=%0d we=%b be=%b wdata=%h addr=%h required 2/1/%b/%h/%h",
                 i, lat, we, be, wd, a, bes[i], wds[i], {adrs[i][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_misaligned();
    logic        wrs  [4];
    logic [2:0]  f3s  [4];
    logic [31:0] adrs [4];
    bit req_seen;
    wrs  = '{1'b0, 1'b1, 1'b0, 1'b1};
    f3s  = '{3'b010, 3'b001, 3'b101, 3'b010};
    adrs = '{32'h102, 32'h101, 32'h103, 32'h101};
    ack_delay = 1;
    for (int i = 0; i < 4; i++) begin
      req_seen = 1'b0;
      set_op(~wrs[i], wrs[i], f3s[i], adrs[i], 32'h11223344);
      @(negedge Clk_i);
      checks++;
      if (Misaligned_o !== 1'b1 || Stall_o !== 1'b0) begin
        errors++;
        $display("FAIL misaligned[%0d]: Misaligned_o=%b Stall_o=%b required 1/0", i, Misaligned_o, Stall_o);
      end
      for (int c = 0; c < 3; c++) begin
        if (dmem.DmemReq_o !== 1'b0) req_seen = 1'b1;
        @(posedge Clk_i); #1;
        @(negedge Clk_i);
      end
      if (dmem.DmemReq_o !== 1'b0) req_seen = 1'b1;
      checks++;
      if (req_seen) begin
        errors++; $display("FAIL misaligned_req[%0d]: DmemReq_o asserted, required never", i);
      end
      @(posedge Clk_i); #1;
      clr_op();
    end
    @(negedge Clk_i);
    checks++;
    if (Misaligned_o !== 1'b0 || Stall_o !== 1'b0) begin
      errors++; $display("FAIL idle_outputs: Misaligned_o=%b Stall_o=%b required 0/0", Misaligned_o, Stall_o);
    end
    @(posedge Clk_i); #1;
  endtask

  task automatic test_timeout();
    int lat, st, rq;
    logic [31:0] a, wd;
    logic [3:0] be;
    logic we;
    ack_delay = -1;
    mem_rdata = 32'hA5A5A5A5;
    expect_result(32'h0, 1'b1);
    run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, lat, st, rq, a, be, wd, we);
    checks++;
    if (lat != 5 || rq != 4 || st != 5) begin
      errors++; $display("FAIL timeout: lat=%0d req=%0d stall=%0d required 5/4/5", lat, rq, st);
    end
    ack_delay = 4;
    mem_rdata = 32'h13579BDF;
    expect_result(32'h13579BDF, 1'b0);
    run_op(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, lat, st, rq, a, be, wd, we);
    checks++;
    if (lat != 5 || rq != 4) begin
      errors++; $display("FAIL ack_at_limit: lat=%0d req=%0d required 5/4", lat, rq);
    end
  endtask

  task automatic test_back_to_back();
    int lat, st, rq;
    logic [31:0] a, wd;
    logic [3:0] be;
    logic we;
    ack_delay = 1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 32'h11111111 * (i + 1);
      expect_result(32'h11111111 * (i + 1), 1'b0);
      run_op(1'b1, 1'b0, 3'b010, 32'h10 + 32'(4 * i), 32'h0, lat, st, rq, a, be, wd, we);
      checks++;
      if (lat != 2 || a !== 32'h10 + 32'(4 * i)) begin
        errors++; $display("FAIL back_to_back[%0d]: lat=%0d addr=%h required 2/%h", i, lat, a, 32'h10 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int lat, st, rq;
    logic [31:0] a, wd;
    logic [3:0] be;
    logic we;
    ack_delay = -1;
    set_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    repeat (2) begin
      @(posedge Clk_i); #1;
    end
    checks++;
    if (dmem.DmemReq_o !== 1'b1 || Stall_o !== 1'b1) begin
      errors++; $display("FAIL mid_wait: DmemReq_o=%b Stall_o=%b required 1/1", dmem.DmemReq_o, Stall_o);
    end
    Rst_i = 1'b1;
    #1;
    checks++;
    if (dmem.DmemReq_o !== 1'b0 || Stall_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: DmemReq_o=%b Stall_o=%b required 0/0", dmem.DmemReq_o, Stall_o);
    end
    @(posedge Clk_i); #1;
    clr_op();
    resp_en = 1'b0;
    dmem.DmemAck_i = 1'b1;
    dmem.DmemRdata_i = 32'hFFFFFFFF;
    Rst_i = 1'b0;
    @(negedge Clk_i);
    checks++;
    if (Stall_o !== 1'b0 || dmem.DmemReq_o !== 1'b0 || Done_o !== 1'b0) begin
      errors++; $display("FAIL late_ack: Stall_o=%b DmemReq_o=%b Done_o=%b required 0/0/0", Stall_o, dmem.DmemReq_o, Done_o);
    end
    @(posedge Clk_i); #1;
    dmem.DmemAck_i = 1'b0;
    dmem.DmemRdata_i = 32'h0;
    resp_en = 1'b1;
    @(negedge Clk_i);
    checks++;
    if (Done_o !== 1'b0 || Stall_o !== 1'b0) begin
      errors++; $display("FAIL after_late_ack: Done_o=%b Stall_o=%b required 0/0", Done_o, Stall_o);
    end
    @(posedge Clk_i); #1;
    ack_delay = 1;
    mem_rdata = 32'h76543210;
    expect_result(32'h0, 1'b0);
    run_op(1'b0, 1'b1, 3'b010, 32'h600, 32'h89ABCDEF, lat, st, rq, a, be, wd, we);
    checks++;
    if (lat != 2 || st != 2 || we !== 1'b1 || be !== 4'b1111 || wd !== 32'h89ABCDEF || a !== 32'h600) begin
      errors++;
      $display("FAIL sw_after_reset: lat=%0d stall=%0d we=%b be=%b wdata=%h addr=%h required 2/2/1/1111/89abcdef/00000600",
               lat, st, we, be, wd, a);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    repeat (2) @(negedge Clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
